// File: rtl/ras_spec_if.sv
// Return-address stack port bundle.
// Predictor requests in, prediction and status out.
interface ras_spec_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 4,
  parameter int JRNL_W = 2
);
  logic            push;
  logic            pop;
  logic [XLEN-1:0] pc_add_4;
  logic            rollback;
  logic            commit;
  logic [XLEN-1:0] jalr_pc_prediction;
  logic            pred_valid;
  logic [ADDR_W:0] count;
  logic [JRNL_W:0] jrnl_count;
  logic            overflow;

  modport master (
    output push, pop, pc_add_4, rollback, commit,
    input  jalr_pc_prediction, pred_valid, count,
    input  jrnl_count, overflow
  );

  modport slave (
    input  push, pop, pc_add_4, rollback, commit,
    output jalr_pc_prediction, pred_valid, count,
    output jrnl_count, overflow
  );
endinterface

// File: rtl/ras_spec.sv
// Circular return-address stack with a small undo journal
// so mispredicted calls/returns can be rolled back exactly.
module ras_spec #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 4,
  parameter int JRNL_W = 2
) (
  input logic     clk,
  input logic     rst_n,
  ras_spec_if.slave rif
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int JDEPTH = 1 << JRNL_W;

  localparam logic [ADDR_W-1:0] T_ONE  = 1;
  localparam logic [ADDR_W:0]   C_ONE  = 1;
  localparam logic [ADDR_W:0]   C_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [JRNL_W-1:0] H_ONE  = 1;
  localparam logic [JRNL_W:0]   J_ONE  = 1;
  localparam logic [JRNL_W:0]   J_TWO  = 2;
  localparam logic [JRNL_W:0]   J_FULL = {1'b1, {JRNL_W{1'b0}}};

  typedef enum logic [1:0] {
    OP_PUSH, OP_POP, OP_REPL, OP_NOP
  } op_e;

  typedef struct packed {
    op_e             op;
    logic [XLEN-1:0] val;
    logic [ADDR_W:0] cnt;
  } jrnl_t;

  logic [XLEN-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] tos;
  logic [ADDR_W:0]   cnt;
  jrnl_t             jrnl [JDEPTH];
  logic [JRNL_W-1:0] jhead;
  logic [JRNL_W:0]   jcnt;
  logic              ovf;

  logic [ADDR_W-1:0] tos_p1, tos_m1;
  logic              full, do_rb, do_cm, do_op;
  logic [JRNL_W-1:0] jnew;
  jrnl_t             undo, ent;
  logic [JRNL_W-1:0] jhead_n, h1, jwr_idx;
  logic [JRNL_W:0]   jcnt_n, c1;
  logic              jwr;

  assign tos_p1 = tos + T_ONE;
  assign tos_m1 = tos - T_ONE;
  assign full   = cnt == C_FULL;
  assign do_rb  = rif.rollback && jcnt != '0;
  assign do_cm  = rif.commit && jcnt != '0;
  assign do_op  = !rif.rollback && (rif.push || rif.pop);
  assign jnew   = jhead + jcnt[JRNL_W-1:0] - H_ONE;
  assign undo   = jrnl[jnew];

  // Capture whatever the op is about to destroy.
  always_comb begin
    ent.op  = OP_NOP;
    ent.val = '0;
    ent.cnt = cnt;
    unique case (1'b1)
      rif.push && rif.pop: begin
        ent.op  = OP_REPL;
        ent.val = mem[tos];
      end
      rif.push && !rif.pop: begin
        ent.op  = OP_PUSH;
        ent.val = mem[tos_p1];
      end
      rif.pop && !rif.push && cnt != '0:
        ent.op = OP_POP;
      default: ;
    endcase
  end

  // Commit retires first; a full journal then drops its oldest.
  always_comb begin
    jhead_n = jhead;
    jcnt_n  = jcnt;
    jwr     = 1'b0;
    jwr_idx = '0;
    h1      = do_cm ? jhead + H_ONE : jhead;
    c1      = do_cm ? jcnt - J_ONE : jcnt;
    if (do_rb) begin
      if (do_cm && jcnt > J_ONE) begin
        jhead_n = jhead + H_ONE;
        jcnt_n  = jcnt - J_TWO;
      end else begin
        jcnt_n = jcnt - J_ONE;
      end
    end else if (!rif.rollback) begin
      jhead_n = h1;
      jcnt_n  = c1;
      if (do_op) begin
        jwr     = 1'b1;
        jwr_idx = h1 + c1[JRNL_W-1:0];
        if (c1 == J_FULL) jhead_n = h1 + H_ONE;
        else              jcnt_n  = c1 + J_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int i = 0; i < JDEPTH; i++) jrnl[i] <= '0;
      tos   <= '0;
      cnt   <= '0;
      jhead <= '0;
      jcnt  <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf   <= do_op && rif.push && !rif.pop && full;
      jhead <= jhead_n;
      jcnt  <= jcnt_n;
      if (jwr) jrnl[jwr_idx] <= ent;
      if (do_rb) begin
        unique case (undo.op)
          OP_PUSH: begin
            mem[tos] <= undo.val;
            tos      <= tos_m1;
            cnt      <= undo.cnt;
          end
          OP_POP: begin
            tos <= tos_p1;
            cnt <= undo.cnt;
          end
          OP_REPL: begin
            mem[tos] <= undo.val;
            cnt      <= undo.cnt;
          end
          default: ;
        endcase
      end else if (do_op) begin
        if (rif.push && rif.pop) begin
          mem[tos] <= rif.pc_add_4;
          if (cnt == '0) cnt <= C_ONE;
        end else if (rif.push) begin
          tos         <= tos_p1;
          mem[tos_p1] <= rif.pc_add_4;
          if (!full) cnt <= cnt + C_ONE;
        end else if (cnt != '0) begin
          tos <= tos_m1;
          cnt <= cnt - C_ONE;
        end
      end
    end
  end

  assign rif.jalr_pc_prediction = mem[tos];
  assign rif.pred_valid         = cnt != '0;
  assign rif.count              = cnt;
  assign rif.jrnl_count         = jcnt;
  assign rif.overflow           = ovf;
endmodule

// File: tb/tb_ras_spec.sv
// Directed bench for ras_spec: stack ops, wrap, journal
// rollback/commit and reset behaviour.
module tb_ras_spec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ras_spec_if rif ();

  ras_spec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rif   (rif)
  );

  task automatic cyc(input logic pu, input logic po,
                     input logic [31:0] pc,
                     input logic rb, input logic cm);
    @(negedge clk);
    rif.push     = pu;
    rif.pop      = po;
    rif.pc_add_4 = pc;
    rif.rollback = rb;
    rif.commit   = cm;
    @(posedge clk);
    #1;
    rif.push     = 1'b0;
    rif.pop      = 1'b0;
    rif.rollback = 1'b0;
    rif.commit   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rif.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", rif.count); end
    checks++; if (rif.pred_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rif.pred_valid); end
    checks++; if (rif.jalr_pc_prediction !== 32'h0) begin errors++; $display("FAIL reset_pred got %h exp 0", rif.jalr_pc_prediction); end
    checks++; if (rif.jrnl_count !== 3'd0) begin errors++; $display("FAIL reset_jrnl got %0d exp 0", rif.jrnl_count); end
    checks++; if (rif.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", rif.overflow); end
  endtask

  task automatic test_basic();
    do_reset();
    cyc(1, 0, 32'h100, 0, 0);
    cyc(1, 0, 32'h200, 0, 0);
    cyc(1, 0, 32'h300, 0, 0);
    checks++; if (rif.jalr_pc_prediction !== 32'h300) begin errors++; $display("FAIL basic_pred3 got %h exp 300", rif.jalr_pc_prediction); end
    checks++; if (rif.count !== 5'd3) begin errors++; $display("FAIL basic_count3 got %0d exp 3", rif.count); end
    cyc(0, 1, 32'h0, 0, 0);
    cyc(0, 1, 32'h0, 0, 0);
    checks++; if (rif.jalr_pc_prediction !== 32'h100) begin errors++; $display("FAIL basic_pred1 got %h exp 100", rif.jalr_pc_prediction); end
    checks++; if (rif.count !== 5'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", rif.count); end
    checks++; if (rif.pred_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", rif.pred_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(1, 0, 32'h1000 + 32'(4 * i), 0, 0);
      checks++; if (rif.overflow !== (i == 16)) begin errors++; $display("FAIL ovf_pulse_%0d got %b exp %b", i, rif.overflow, (i == 16)); end
    end
    checks++; if (rif.count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", rif.count); end
    checks++; if (rif.jalr_pc_prediction !== 32'h1040) begin errors++; $display("FAIL ovf_pred got %h exp 1040", rif.jalr_pc_prediction); end
    checks++; if (rif.jrnl_count !== 3'd4) begin errors++; $display("FAIL ovf_jrnl_sat got %0d exp 4", rif.jrnl_count); end
    for (int i = 0; i < 16; i++) cyc(0, 1, 32'h0, 0, 0);
    checks++; if (rif.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", rif.overflow); end
    checks++; if (rif.count !== 5'd0) begin errors++; $display("FAIL ovf_drain_count got %0d exp 0", rif.count); end
    checks++; if (rif.pred_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_valid got %b exp 0", rif.pred_valid); end
  endtask

  task automatic test_rollback_seq();
    logic [31:0] ep [3];
    logic [4:0]  ec [3];
    logic [2:0]  ej [3];
    ep[0] = 32'hB0; ep[1] = 32'hC0; ep[2] = 32'hB0;
    ec[0] = 5'd2;   ec[1] = 5'd3;   ec[2] = 5'd2;
    ej[0] = 3'd2;   ej[1] = 3'd1;   ej[2] = 3'd0;
    do_reset();
    cyc(1, 0, 32'hA0, 0, 0);
    cyc(1, 0, 32'hB0, 0, 0);
    cyc(0, 0, 32'h0, 0, 1);
    cyc(0, 0, 32'h0, 0, 1);
    checks++; if (rif.jrnl_count !== 3'd0) begin errors++; $display("FAIL rbs_committed got %0d exp 0", rif.jrnl_count); end
    cyc(1, 0, 32'hC0, 0, 0);
    cyc(0, 1, 32'h0, 0, 0);
    cyc(0, 1, 32'h0, 0, 0);
    checks++; if (rif.jalr_pc_prediction !== 32'hA0) begin errors++; $display("FAIL rbs_pre got %h exp a0", rif.jalr_pc_prediction); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'h0, 1, 0);
      checks++; if (rif.jalr_pc_prediction !== ep[i]) begin errors++; $display("FAIL rbs_pred_%0d got %h exp %h", i, rif.jalr_pc_prediction, ep[i]); end
      checks++; if (rif.count !== ec[i]) begin errors++; $display("FAIL rbs_count_%0d got %0d exp %0d", i, rif.count, ec[i]); end
      checks++; if (rif.jrnl_count !== ej[i]) begin errors++; $display("FAIL rbs_jrnl_%0d got %0d exp %0d", i, rif.jrnl_count, ej[i]); end
    end
  endtask

  task automatic test_wrap_undo();
    do_reset();
    for (int i = 1; i <= 16; i++) cyc(1, 0, 32'(16 * i), 0, 0);
    cyc(1, 0, 32'h99, 0, 0);
    checks++; if (rif.jalr_pc_prediction !== 32'h99) begin errors++; $display("FAIL wrap_pred got %h exp 99", rif.jalr_pc_prediction); end
    cyc(0, 0, 32'h0, 1, 0);
    checks++; if (rif.jalr_pc_prediction !== 32'h100) begin errors++; $display("FAIL wrap_undo_pred got %h exp 100", rif.jalr_pc_prediction); end
    checks++; if (rif.count !== 5'd16) begin errors++; $display("FAIL wrap_undo_count got %0d exp 16", rif.count); end
    for (int i = 0; i < 15; i++) cyc(0, 1, 32'h0, 0, 0);
    checks++; if (rif.jalr_pc_prediction !== 32'h10) begin errors++; $display("FAIL wrap_oldest got %h exp 10", rif.jalr_pc_prediction); end
  endtask

  task automatic test_replace();
    do_reset();
    cyc(1, 1, 32'h44, 0, 0);
    checks++; if (rif.count !== 5'd1) begin errors++; $display("FAIL repl_empty_count got %0d exp 1", rif.count); end
    cyc(0, 0, 32'h0, 1, 0);
    checks++; if (rif.count !== 5'd0) begin errors++; $display("FAIL repl_empty_undo got %0d exp 0", rif.count); end
    cyc(1, 0, 32'h50, 0, 0);
    cyc(1, 1, 32'h60, 0, 0);
    checks++; if (rif.jalr_pc_prediction !== 32'h60) begin errors++; $display("FAIL repl_pred got %h exp 60", rif.jalr_pc_prediction); end
    checks++; if (rif.count !== 5'd1) begin errors++; $display("FAIL repl_count got %0d exp 1", rif.count); end
    cyc(0, 0, 32'h0, 1, 0);
    checks++; if (rif.jalr_pc_prediction !== 32'h50) begin errors++; $display("FAIL repl_undo got %h exp 50", rif.jalr_pc_prediction); end
  endtask

  task automatic test_jrnl_depth();
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1, 0, 32'(i), 0, 0);
    checks++; if (rif.jrnl_count !== 3'd4) begin errors++; $display("FAIL jd_full got %0d exp 4", rif.jrnl_count); end
    for (int i = 0; i < 5; i++) cyc(0, 0, 32'h0, 1, 0);
    checks++; if (rif.count !== 5'd1) begin errors++; $display("FAIL jd_count got %0d exp 1", rif.count); end
    checks++; if (rif.jalr_pc_prediction !== 32'h1) begin errors++; $display("FAIL jd_pred got %h exp 1", rif.jalr_pc_prediction); end
    cyc(0, 0, 32'h0, 0, 1);
    checks++; if (rif.jrnl_count !== 3'd0) begin errors++; $display("FAIL jd_empty_commit got %0d exp 0", rif.jrnl_count); end
    cyc(0, 1, 32'h0, 0, 0);
    cyc(0, 1, 32'h0, 0, 0);
    checks++; if (rif.count !== 5'd0) begin errors++; $display("FAIL jd_nop_pop got %0d exp 0", rif.count); end
    checks++; if (rif.jrnl_count !== 3'd2) begin errors++; $display("FAIL jd_nop_jrnl got %0d exp 2", rif.jrnl_count); end
    cyc(0, 0, 32'h0, 1, 0);
    checks++; if (rif.count !== 5'd0) begin errors++; $display("FAIL jd_nop_undo got %0d exp 0", rif.count); end
  endtask

  task automatic test_commit_combo();
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1, 0, 32'(i), 0, 0);
    cyc(1, 0, 32'h4, 0, 1);
    checks++; if (rif.jrnl_count !== 3'd3) begin errors++; $display("FAIL cc_push_jrnl got %0d exp 3", rif.jrnl_count); end
    checks++; if (rif.count !== 5'd4) begin errors++; $display("FAIL cc_push_count got %0d exp 4", rif.count); end
    cyc(0, 0, 32'h0, 1, 1);
    checks++; if (rif.jrnl_count !== 3'd1) begin errors++; $display("FAIL cc_rb2_jrnl got %0d exp 1", rif.jrnl_count); end
    checks++; if (rif.jalr_pc_prediction !== 32'h3) begin errors++; $display("FAIL cc_rb2_pred got %h exp 3", rif.jalr_pc_prediction); end
    cyc(0, 0, 32'h0, 1, 1);
    checks++; if (rif.jrnl_count !== 3'd0) begin errors++; $display("FAIL cc_rb1_jrnl got %0d exp 0", rif.jrnl_count); end
    checks++; if (rif.jalr_pc_prediction !== 32'h2) begin errors++; $display("FAIL cc_rb1_pred got %h exp 2", rif.jalr_pc_prediction); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(1, 0, 32'h11, 0, 0);
    cyc(1, 0, 32'h22, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rif.count !== 5'd0) begin errors++; $display("FAIL mr_async_count got %0d exp 0", rif.count); end
    checks++; if (rif.jalr_pc_prediction !== 32'h0) begin errors++; $display("FAIL mr_async_pred got %h exp 0", rif.jalr_pc_prediction); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 32'h77, 0, 0);
    checks++; if (rif.count !== 5'd1) begin errors++; $display("FAIL mr_count got %0d exp 1", rif.count); end
    checks++; if (rif.jrnl_count !== 3'd1) begin errors++; $display("FAIL mr_jrnl got %0d exp 1", rif.jrnl_count); end
    cyc(0, 0, 32'h0, 1, 0);
    checks++; if (rif.pred_valid !== 1'b0) begin errors++; $display("FAIL mr_undo_valid got %b exp 0", rif.pred_valid); end
    checks++; if (rif.jalr_pc_prediction !== 32'h0) begin errors++; $display("FAIL mr_undo_pred got %h exp 0", rif.jalr_pc_prediction); end
  endtask

  initial begin
    rif.push     = 1'b0;
    rif.pop      = 1'b0;
    rif.pc_add_4 = '0;
    rif.rollback = 1'b0;
    rif.commit   = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_rollback_seq();
    test_wrap_undo();
    test_replace();
    test_jrnl_depth();
    test_commit_combo();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ras_spec.md
RAS_SPEC -- requirements
Module: ras_spec

Interface
REQ-001 Parameter XLEN, default 32, return-address width.
REQ-002 Parameter ADDR_W, default 4, stack depth DEPTH = 2^ADDR_W.
REQ-003 Parameter JRNL_W, default 2, undo-journal depth JDEPTH = 2^JRNL_W.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 push  in  1  call seen; push pc_add_4.
REQ-007 pop  in  1  return seen; pop top entry.
REQ-008 pc_add_4  in  XLEN  return address to push.
REQ-009 rollback  in  1  undo most recent un-committed journaled operation.
REQ-010 commit  in  1  retire oldest journal entry (no longer undoable).
REQ-011 jalr_pc_prediction  out  XLEN  current top-of-stack value, combinational from state.
REQ-012 pred_valid  out  1  count != 0.
REQ-013 count  out  ADDR_W+1  live entries, 0..DEPTH.
REQ-014 jrnl_count  out  JRNL_W+1  undoable entries, 0..JDEPTH.
REQ-015 overflow  out  1  one-cycle pulse when a push overwrote the oldest entry (count was DEPTH).

Function
REQ-016 Storage: circular array of DEPTH x XLEN, top pointer tos (ADDR_W bits, modulo-DEPTH wrap).
REQ-017 Push only: tos <= tos+1; mem[tos+1] <= pc_add_4; count <= min(count+1, DEPTH); overflow pulses if count was DEPTH.
REQ-018 Pop only, count>0: tos <= tos-1; count <= count-1; mem unchanged.
REQ-019 Pop only, count==0: no stack change; journaled as NOP.
REQ-020 Push and pop same cycle (replace): mem[tos] <= pc_add_4; tos unchanged; count unchanged, except count 0 becomes 1 (tos unchanged).
REQ-021 Every push/pop cycle without rollback appends one journal entry {op: PUSH/POP/REPL/NOP, saved_val = mem value about to be overwritten (PUSH: mem[tos+1], REPL: mem[tos]), saved_count = count before}.
REQ-022 Journal full (jrnl_count==JDEPTH) on append: oldest entry discarded, new entry appended, jrnl_count stays JDEPTH.
REQ-023 Rollback, jrnl_count>0: newest entry removed and undone in one cycle; push, pop ignored that cycle.
REQ-024 Undo PUSH: mem[tos] <= saved_val; tos <= tos-1; count <= saved_count.
REQ-025 Undo POP: tos <= tos+1; count <= saved_count.
REQ-026 Undo REPL: mem[tos] <= saved_val; count <= saved_count.
REQ-027 Undo NOP: no stack change.
REQ-028 Rollback with jrnl_count==0: no state change.
REQ-029 Commit, jrnl_count>0: oldest entry dropped; may coincide with push/pop (net jrnl_count unchanged) or rollback (net jrnl_count -2 when ≥2 entries; if exactly 1 entry, both refer to it and it is rolled back, jrnl_count becomes 0).
REQ-030 Commit with jrnl_count==0: ignored.
REQ-031 Outputs jalr_pc_prediction = mem[tos], pred_valid, count reflect registered state; zero-latency read, one-cycle update latency.
REQ-032 Stack contents after a rollback sequence SHALL be bit-identical to state before the undone operations, including entries overwritten by wrap-around.

Reset
REQ-033 On rst_n low, asynchronously: all mem entries 0, tos 0, count 0, journal empty, overflow 0, jalr_pc_prediction 0, pred_valid 0, jrnl_count 0.
REQ-034 Reset asserted mid-operation discards all journal and stack state; first cycle after release behaves as empty stack.

Verification
REQ-035 Push 0x100, 0x200, 0x300 -> prediction 0x300, count 3; pop twice -> prediction 0x100, count 1.
REQ-036 Defaults: 17 pushes of 0x1000+4*i (i=0..16) -> overflow pulses on 17th only, count 16, prediction 0x1040; 16 pops -> count 0, pred_valid 0.
REQ-037 Stack [0xA0,0xB0]; push 0xC0, pop, pop; 3 rollbacks -> prediction 0xB0, count 2, jrnl_count 0, after each step state matches pre-op state.
REQ-038 Full stack oldest entry 0x10 (count 16); push 0x99 overwrites 0x10; rollback -> mem slot restored to 0x10, count 16, prediction equal to pre-push top.
REQ-039 Push and pop same cycle on top 0x50 with pc_add_4 0x60 -> prediction 0x60, count unchanged; rollback -> 0x50.
REQ-040 Five pushes (journal depth 4) then five rollbacks -> only four undone, fifth rollback no-op, count 1; commit with empty journal ignored.
